// File: rtl/bcm_frame_reader_if.sv
// Bus bundle between the BCM frame reader and the brightness memory / host side.
// The master side drives enable, the write pointer and the memory read data.
// The slave side (the reader) returns the read pointer, the LED drive, the done pulse and the empty flag.
interface bcm_frame_reader_if;
  logic       enable;
  logic [6:0] wr_addr;
  logic [7:0] rd_data;
  logic [6:0] rd_addr;
  logic       bcm_out;
  logic       sample_done;
  logic       empty;

  modport master (
    output enable, wr_addr, rd_data,
    input  rd_addr, bcm_out, sample_done, empty
  );

  modport slave (
    input  enable, wr_addr, rd_data,
    output rd_addr, bcm_out, sample_done, empty
  );
endinterface

// File: rtl/bcm_frame_reader.sv
// BCM frame reader: pulls 8-bit brightness samples from a synchronous-read memory
// and plays each one out as binary-code modulation. Bit-plane k is shown for
// (2^k)*UNIT_CYCLES clocks, so a whole sample lasts 255*UNIT_CYCLES clocks.
module bcm_frame_reader #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  bcm_frame_reader_if.slave bus
);

  // The longest plane (plane 7) lasts 128*UNIT_CYCLES clocks; the counter must reach that minus one.
  localparam int SLOT_W = $clog2(128 * UNIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    PLANE
  } state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [6:0]        rd_addr_q, rd_addr_d;
  logic [7:0]        value_q, value_d;
  logic [2:0]        plane_q, plane_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              bcm_out_q, bcm_out_d;

  logic [SLOT_W:0]   plane_len;
  logic [SLOT_W:0]   plane_len_m1;
  logic              plane_last;
  logic              sample_end;
  logic              empty;

  // State and datapath registers; reset clears everything and aborts any sample in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      rd_addr_q <= '0;
      value_q   <= '0;
      plane_q   <= '0;
      slot_q    <= '0;
      bcm_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rd_addr_q <= rd_addr_d;
      value_q   <= value_d;
      plane_q   <= plane_d;
      slot_q    <= slot_d;
      bcm_out_q <= bcm_out_d;
    end
  end

  // Plane length bookkeeping: flags the final clock of the current plane and of the whole sample.
  always_comb begin
    plane_len    = (SLOT_W + 1)'(UNIT_CYCLES) << plane_q;
    plane_len_m1 = plane_len - (SLOT_W + 1)'(1);
    plane_last   = ({1'b0, slot_q} == plane_len_m1);
    sample_end   = (state_q == PLANE) && (plane_q == 3'd7) && plane_last;
    empty        = (rd_addr_q == bus.wr_addr);
  end

  // Next-state and datapath update; ready_q holds off the first start for one clock after reset.
  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b1;
    rd_addr_d = rd_addr_q;
    value_d   = value_q;
    plane_d   = plane_q;
    slot_d    = slot_q;

    case (state_q)
      IDLE: begin
        if (ready_q && bus.enable && !empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        value_d = bus.rd_data;
        plane_d = 3'd0;
        slot_d  = '0;
        state_d = PLANE;
      end
      PLANE: begin
        if (plane_last) begin
          slot_d = '0;
          if (plane_q == 3'd7) begin
            plane_d   = 3'd0;
            rd_addr_d = rd_addr_q + 7'd1;
            state_d   = IDLE;
          end else begin
            plane_d = plane_q + 3'd1;
          end
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bcm_out_d = (state_d == PLANE) ? value_d[plane_d] : 1'b0;
  end

  // Outputs: the LED drive comes straight from its flop, the rest from state and pointers.
  always_comb begin
    bus.rd_addr     = rd_addr_q;
    bus.bcm_out     = bcm_out_q;
    bus.sample_done = sample_end;
    bus.empty       = empty;
  end

endmodule

// File: tb/tb_bcm_frame_reader.sv
// Self-checking bench for bcm_frame_reader: one instance at UNIT_CYCLES=4 for the
// main scenarios and one at UNIT_CYCLES=1 to reach the pointer wrap quickly.
module tb_bcm_frame_reader;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  bcm_frame_reader_if bus0 ();
  bcm_frame_reader_if bus1 ();

  bcm_frame_reader #(.UNIT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  bcm_frame_reader #(.UNIT_CYCLES(1)) dut_u1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  logic [7:0] mem0 [128];
  logic [7:0] mem1 [128];

  // Synchronous-read brightness memories, one clock of latency.
  always @(posedge clk) begin
    bus0.rd_data <= mem0[bus0.rd_addr];
    bus1.rd_data <= mem1[bus1.rd_addr];
  end

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit hist0 [65536];
  bit hist1 [65536];

  // Record the LED drive of both instances once per clock, away from the rising edge.
  always @(negedge clk) begin
    if (cyc < 65536) begin
      hist0[cyc] = bus0.bcm_out;
      hist1[cyc] = bus1.bcm_out;
    end
    cyc++;
  end

  typedef struct {
    logic [7:0] value;
    int         exp_high;
    int         exp_rd_next;
  } vec_t;

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    tests_run++;
    if (actual < lo || actual > hi) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int which, input logic en, input logic [6:0] wa);
    if (which == 0) begin
      bus0.enable  = en;
      bus0.wr_addr = wa;
    end else begin
      bus1.enable  = en;
      bus1.wr_addr = wa;
    end
  endtask

  // Expected drive at PLANE cycle i of a sample: find which plane cycle i falls in.
  function automatic bit exp_bit(input logic [7:0] v, input int unit, input int i);
    int acc = 0;
    int k   = 0;
    while (k < 7 && i >= acc + (unit << k)) begin
      acc += unit << k;
      k++;
    end
    return v[k];
  endfunction

  task automatic wait_done(input int which, input string name, input int bound, output int dc);
    logic d;
    dc = -1;
    for (int n = 0; n < bound; n++) begin
      next_cycle();
      d = (which != 0) ? bus1.sample_done : bus0.sample_done;
      if (d) begin
        dc = cyc - 1;
        break;
      end
    end
    check_output({name, " done seen"}, (dc >= 0) ? 1 : 0, 1);
  endtask

  task automatic watch(input int which, input int n, output int highs, output int dones);
    highs = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      next_cycle();
      highs += (which != 0) ? int'(bus1.bcm_out) : int'(bus0.bcm_out);
      dones += (which != 0) ? int'(bus1.sample_done) : int'(bus0.sample_done);
    end
  endtask

  // Compare the recorded waveform ending at the sample_done cycle against the plane model.
  task automatic check_sample(input int which, input logic [7:0] value, input int unit,
                              input int dc, input int exp_high, input string name);
    int len;
    int mism;
    int highs;
    int pre;
    bit a;
    len = 255 * unit;
    if (dc < len + 3 || dc >= 65536) return;
    mism  = 0;
    highs = 0;
    pre   = 0;
    for (int i = 0; i < len; i++) begin
      a = (which != 0) ? hist1[dc - len + 1 + i] : hist0[dc - len + 1 + i];
      highs += int'(a);
      if (a != exp_bit(value, unit, i)) mism++;
    end
    for (int j = 1; j <= 3; j++) begin
      pre += (which != 0) ? int'(hist1[dc - len + 1 - j]) : int'(hist0[dc - len + 1 - j]);
    end
    check_output({name, " wave errors"}, mism, 0);
    check_output({name, " high cycles"}, highs, exp_high);
    check_output({name, " low before planes"}, pre, 0);
  endtask

  initial begin
    vec_t vecs [3];
    int   dc;
    int   prev;
    int   r;
    int   highs;
    int   dones;
    int   n;

    vecs[0] = '{value: 8'h00, exp_high: 0,    exp_rd_next: 1};
    vecs[1] = '{value: 8'hFF, exp_high: 1020, exp_rd_next: 2};
    vecs[2] = '{value: 8'h80, exp_high: 512,  exp_rd_next: 3};

    for (int i = 0; i < 128; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end

    rst0 = 1'b1;
    rst1 = 1'b1;
    apply_stimulus(0, 1'b0, 7'd0);
    apply_stimulus(1, 1'b0, 7'd0);
    repeat (3) next_cycle();

    // Reset state
    check_output("reset rd_addr", int'(bus0.rd_addr), 0);
    check_output("reset bcm_out", int'(bus0.bcm_out), 0);
    check_output("reset sample_done", int'(bus0.sample_done), 0);
    check_output("reset empty", int'(bus0.empty), 1);

    // Single sample 0x05 at UNIT_CYCLES=4
    mem0[0] = 8'h05;
    apply_stimulus(0, 1'b1, 7'd1);
    #0;
    check_output("A empty pending", int'(bus0.empty), 0);
    rst0 = 1'b0;
    r    = cyc;
    wait_done(0, "A", 1100, dc);
    check_range("A start after reset", dc - r, 1022, 1024);
    check_sample(0, 8'h05, 4, dc, 20, "A");
    next_cycle();
    check_output("A done pulse width", int'(bus0.sample_done), 0);
    check_output("A rd_addr", int'(bus0.rd_addr), 1);
    check_output("A empty", int'(bus0.empty), 1);
    watch(0, 50, highs, dones);
    check_output("A idle highs", highs, 0);
    check_output("A idle dones", dones, 0);

    // Back-to-back samples from the table
    rst0 = 1'b1;
    next_cycle();
    check_output("B reset rd_addr", int'(bus0.rd_addr), 0);
    for (int i = 0; i < 3; i++) mem0[i] = vecs[i].value;
    apply_stimulus(0, 1'b1, 7'd3);
    next_cycle();
    rst0 = 1'b0;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      wait_done(0, $sformatf("B%0d", i), 1200, dc);
      check_sample(0, vecs[i].value, 4, dc, vecs[i].exp_high, $sformatf("B%0d", i));
      if (i > 0 && prev >= 0 && dc >= 0) check_output($sformatf("B%0d period", i), dc - prev, 1023);
      prev = dc;
      next_cycle();
      check_output($sformatf("B%0d rd_addr", i), int'(bus0.rd_addr), vecs[i].exp_rd_next);
    end
    check_output("B empty", int'(bus0.empty), 1);

    // Enable dropped mid-sample
    mem0[3] = 8'hA5;
    mem0[4] = 8'h3C;
    apply_stimulus(0, 1'b0, 7'd5);
    next_cycle();
    next_cycle();
    apply_stimulus(0, 1'b1, 7'd5);
    r = cyc;
    repeat (40) next_cycle();
    apply_stimulus(0, 1'b0, 7'd5);
    wait_done(0, "C", 1100, dc);
    check_output("C start latency", dc - r, 1021);
    check_sample(0, 8'hA5, 4, dc, 660, "C");
    next_cycle();
    check_output("C rd_addr", int'(bus0.rd_addr), 4);
    check_output("C empty", int'(bus0.empty), 0);
    watch(0, 1100, highs, dones);
    check_output("C disabled highs", highs, 0);
    check_output("C disabled dones", dones, 0);
    check_output("C rd_addr held", int'(bus0.rd_addr), 4);

    // Reset during plane 5 of the sample at address 2
    rst0 = 1'b1;
    next_cycle();
    mem0[0] = 8'h11;
    mem0[1] = 8'h22;
    mem0[2] = 8'hE7;
    apply_stimulus(0, 1'b1, 7'd3);
    rst0 = 1'b0;
    wait_done(0, "D0", 1200, dc);
    check_sample(0, 8'h11, 4, dc, 68, "D0");
    wait_done(0, "D1", 1200, dc);
    check_sample(0, 8'h22, 4, dc, 136, "D1");
    repeat (180) next_cycle();
    check_output("D plane5 bcm_out", int'(bus0.bcm_out), 1);
    check_output("D plane5 rd_addr", int'(bus0.rd_addr), 2);
    #2;
    rst0 = 1'b1;
    #1;
    check_output("D abort bcm_out", int'(bus0.bcm_out), 0);
    check_output("D abort rd_addr", int'(bus0.rd_addr), 0);
    check_output("D abort sample_done", int'(bus0.sample_done), 0);
    watch(0, 3, highs, dones);
    check_output("D in reset dones", dones, 0);
    rst0 = 1'b0;
    wait_done(0, "D2", 1200, dc);
    check_sample(0, 8'h11, 4, dc, 68, "D2");
    apply_stimulus(0, 1'b1, 7'd1);
    next_cycle();
    check_output("D2 rd_addr", int'(bus0.rd_addr), 1);

    // Empty with enable held high
    watch(0, 100, highs, dones);
    check_output("E highs", highs, 0);
    check_output("E dones", dones, 0);
    check_output("E rd_addr", int'(bus0.rd_addr), 1);
    check_output("E empty", int'(bus0.empty), 1);

    // Pointer wrap 127 -> 0 on the UNIT_CYCLES=1 instance
    mem1[127] = 8'h01;
    apply_stimulus(1, 1'b1, 7'd127);
    next_cycle();
    rst1 = 1'b0;
    n = 0;
    while (bus1.rd_addr != 7'd127 && n < 40000) begin
      next_cycle();
      n++;
    end
    check_output("F reached 127", int'(bus1.rd_addr), 127);
    check_output("F empty at 127", int'(bus1.empty), 1);
    apply_stimulus(1, 1'b1, 7'd0);
    #0;
    check_output("F pending", int'(bus1.empty), 0);
    wait_done(1, "F", 400, dc);
    check_sample(1, 8'h01, 1, dc, 1, "F");
    next_cycle();
    check_output("F wrap rd_addr", int'(bus1.rd_addr), 0);
    check_output("F wrap empty", int'(bus1.empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
